// File: rtl/pu_riscv_dext_q_if.sv
// ---------------------------------------------------------------------------
// pu_riscv_dext_q_if
//   Bus bundle between the data-side memory pipeline (mem_*) and the BIU
//   (biu_*) for the queued data external access unit.
//   slave  : view of the queue unit. It takes CPU requests, drives CPU
//            responses, drives BIU requests and takes BIU responses.
//   master : view of the environment, which is the CPU plus the BIU.
//   mem_adro carries the BIU's address out back to the CPU.
//   biu_adri carries the FIFO head address to the BIU.
// ---------------------------------------------------------------------------
interface pu_riscv_dext_q_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  // CPU side
  logic            mem_req;
  logic            mem_rdy;
  logic [XLEN-1:0] mem_adr;
  logic [2:0]      mem_size;
  logic [2:0]      mem_type;
  logic [2:0]      mem_prot;
  logic            mem_lock;
  logic            mem_we;
  logic [XLEN-1:0] mem_d;
  logic            mem_adr_ack;
  logic [PLEN-1:0] mem_adro;
  logic [XLEN-1:0] mem_q;
  logic            mem_ack;
  logic            mem_err;

  // BIU side
  logic            biu_stb;
  logic            biu_stb_ack;
  logic [PLEN-1:0] biu_adri;
  logic [PLEN-1:0] biu_adro;
  logic [2:0]      biu_size;
  logic [2:0]      biu_type;
  logic [2:0]      biu_prot;
  logic            biu_lock;
  logic            biu_we;
  logic [XLEN-1:0] biu_d;
  logic [XLEN-1:0] biu_q;
  logic            biu_ack;
  logic            biu_err;

  modport slave (
    input  mem_req, mem_adr, mem_size, mem_type, mem_prot, mem_lock, mem_we, mem_d,
    output mem_rdy, mem_adr_ack, mem_adro, mem_q, mem_ack, mem_err,
    output biu_stb, biu_adri, biu_size, biu_type, biu_prot, biu_lock, biu_we, biu_d,
    input  biu_stb_ack, biu_adro, biu_q, biu_ack, biu_err
  );

  modport master (
    output mem_req, mem_adr, mem_size, mem_type, mem_prot, mem_lock, mem_we, mem_d,
    input  mem_rdy, mem_adr_ack, mem_adro, mem_q, mem_ack, mem_err,
    input  biu_stb, biu_adri, biu_size, biu_type, biu_prot, biu_lock, biu_we, biu_d,
    output biu_stb_ack, biu_adro, biu_q, biu_ack, biu_err
  );
endinterface

// File: rtl/pu_riscv_dext_q.sv
// ---------------------------------------------------------------------------
// pu_riscv_dext_q
//   Queued data external access unit. It buffers up to QDEPTH CPU requests
//   in a FIFO and keeps up to DEPTH transactions outstanding on the BIU.
//   Locked accesses are serialised so that each one runs alone on the bus.
//   After clr_i, responses still in flight are discarded. Responses return
//   in order and pass through to the CPU combinationally.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : flush the queue and discard in-flight responses
//   bus           : mem_* CPU handshake and biu_* BIU handshake (slave view)
//   inflight_o    : number of outstanding BIU transactions
// ---------------------------------------------------------------------------
module pu_riscv_dext_q #(
  parameter int XLEN   = 64,
  parameter int PLEN   = 64,
  parameter int DEPTH  = 4,
  parameter int QDEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  pu_riscv_dext_q_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_o
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [2:0]      size;
    logic [2:0]      typ;
    logic [2:0]      prot;
    logic            lock;
    logic            we;
    logic [XLEN-1:0] d;
  } req_t;

  req_t            fifo_q [QDEPTH];
  req_t            fifo_d [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QCW-1:0]  count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            locked_pending_q, locked_pending_d;

  req_t head, push_req;
  logic full, empty, mem_rdy, accept, lock_block, issue, pop, rsp, rsp_valid;

  // Wraps modulo QDEPTH. This is also correct for QDEPTH=1, where a plain
  // PW-bit increment would not wrap to zero.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head  = fifo_q[rd_ptr_q];
  assign full  = (count_q == QCW'(QDEPTH));
  assign empty = (count_q == '0);

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign mem_rdy = ~full & ~clr_i;
  assign accept  = bus.mem_req & mem_rdy;

  assign push_req = '{adr: bus.mem_adr, size: bus.mem_size, typ: bus.mem_type,
                      prot: bus.mem_prot, lock: bus.mem_lock, we: bus.mem_we,
                      d: bus.mem_d};

  // A locked head waits for the bus to drain. Once a locked access is
  // issued, nothing follows it until its response comes back.
  assign lock_block = (head.lock & (inflight_q != '0)) | locked_pending_q;
  assign issue      = ~empty & ~clr_i & (inflight_q < CW'(DEPTH)) & ~lock_block;
  assign pop        = issue & bus.biu_stb_ack;

  // A response with nothing outstanding is unsolicited. It is dropped.
  assign rsp       = bus.biu_ack | bus.biu_err;
  assign rsp_valid = rsp & (inflight_q != '0);

  // Request FIFO
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this
    // block leaves a value unassigned and no latch is inferred.
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      // accept and pop are both blocked during clr_i, so the FIFO can
      // simply be marked empty.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (accept) begin
        fifo_d[wr_ptr_q] = push_req;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({accept, pop})
        2'b10:   count_d = count_q + QCW'(1);
        2'b01:   count_d = count_q - QCW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Outstanding, discard and lock tracking
  always_comb begin
    inflight_d       = inflight_q;
    discard_d        = discard_q;
    locked_pending_d = locked_pending_q;

    case ({pop, rsp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    // On clr_i, every response still owed after this cycle is stale.
    if (clr_i)                   discard_d = inflight_q - (rsp_valid ? CW'(1) : CW'(0));
    else if (rsp && discard_q != '0) discard_d = discard_q - CW'(1);

    // A locked access can only pop with nothing in flight, so its set never
    // coincides with a counted response.
    if (pop && head.lock) locked_pending_d = 1'b1;
    else if (rsp_valid)   locked_pending_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the FIFO storage is reset as well. It is only QDEPTH entries,
      // and resetting it keeps the head-driven biu_* outputs at a defined
      // zero during and after reset.
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      inflight_q       <= '0;
      discard_q        <= '0;
      locked_pending_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples values from before the edge.
      fifo_q           <= fifo_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      inflight_q       <= inflight_d;
      discard_q        <= discard_d;
      locked_pending_q <= locked_pending_d;
    end
  end

  // CPU side
  assign bus.mem_rdy     = mem_rdy;
  assign bus.mem_adr_ack = accept;
  assign bus.mem_adro    = bus.biu_adro;
  assign bus.mem_q       = bus.biu_q;
  assign bus.mem_ack     = bus.biu_ack & (discard_q == '0) & (inflight_q != '0) & ~clr_i;
  assign bus.mem_err     = bus.biu_err & (discard_q == '0) & (inflight_q != '0) & ~clr_i;

  // BIU side: the fields always show the FIFO head
  assign bus.biu_stb  = issue;
  assign bus.biu_adri = PLEN'(head.adr);
  assign bus.biu_size = head.size;
  assign bus.biu_type = head.typ;
  assign bus.biu_prot = head.prot;
  assign bus.biu_lock = head.lock;
  assign bus.biu_we   = head.we;
  assign bus.biu_d    = head.d;

  assign inflight_o = inflight_q;

endmodule

// File: tb/tb_pu_riscv_dext_q.sv
// ---------------------------------------------------------------------------
// tb_pu_riscv_dext_q
//   Directed bench for pu_riscv_dext_q with DEPTH=2 and QDEPTH=2. Each BIU
//   response that should reach the CPU pushes its expected result into a
//   queue. A negedge monitor pops the queue and compares it whenever the DUT
//   raises mem_ack/mem_err. Request-side behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_pu_riscv_dext_q;

  localparam int XLEN = 64;
  localparam int PLEN = 64;

  typedef struct {
    logic            ack;
    logic            err;
    logic [XLEN-1:0] q;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] inflight;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  pu_riscv_dext_q_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

  pu_riscv_dext_q #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(2), .QDEPTH(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (clr),
    .bus        (bus.slave),
    .inflight_o (inflight)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [63:0] adr, input logic lock, input logic we,
                           input logic [63:0] d);
    bus.mem_req  = 1'b1;
    bus.mem_adr  = adr;
    bus.mem_lock = lock;
    bus.mem_we   = we;
    bus.mem_d    = d;
    bus.mem_size = 3'd3;
    bus.mem_type = 3'd0;
    bus.mem_prot = 3'd1;
  endtask

  task automatic respond(input logic ack, input logic err, input logic [63:0] q,
                         input bit expect_cpu);
    rsp_t r;
    bus.biu_ack = ack;
    bus.biu_err = err;
    bus.biu_q   = q;
    if (expect_cpu) begin
      r.ack = ack; r.err = err; r.q = q;
      exp_q.push_back(r);
    end
  endtask

  task automatic rsp_idle();
    bus.biu_ack = 1'b0;
    bus.biu_err = 1'b0;
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (bus.mem_ack || bus.mem_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cpu_rsp", {62'd0, bus.mem_ack, bus.mem_err}, 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_ack_err", {62'd0, bus.mem_ack, bus.mem_err}, {62'd0, e.ack, e.err});
        if (e.ack) check("rsp_q", bus.mem_q, e.q);
      end
    end
  end

  initial begin
    bus.mem_req = 0; bus.mem_adr = '0; bus.mem_size = '0; bus.mem_type = '0;
    bus.mem_prot = '0; bus.mem_lock = 0; bus.mem_we = 0; bus.mem_d = '0;
    bus.biu_stb_ack = 0; bus.biu_adro = '0; bus.biu_q = '0;
    bus.biu_ack = 0; bus.biu_err = 0;

    // Reset values
    #3;
    check("rst_mem_rdy",  bus.mem_rdy, 1);
    check("rst_biu_stb",  bus.biu_stb, 0);
    check("rst_adr_ack",  bus.mem_adr_ack, 0);
    check("rst_mem_ack",  {bus.mem_ack, bus.mem_err}, 0);
    check("rst_inflight", inflight, 0);
    check("rst_biu_adri", bus.biu_adri, 0);
    step(); step();
    rst_n = 1'b1;

    // Single read
    step();
    drive_req(64'h1000, 0, 0, 64'h0);
    #1 check("s1_adr_ack", bus.mem_adr_ack, 1);
    check("s1_no_bypass", bus.biu_stb, 0);
    step();
    bus.mem_req = 0;
    #1 check("s1_stb", bus.biu_stb, 1);
    check("s1_adri", bus.biu_adri, 64'h1000);
    bus.biu_stb_ack = 1;
    step();
    bus.biu_stb_ack = 0;
    #1 check("s1_inflight1", inflight, 1);
    check("s1_stb_low", bus.biu_stb, 0);
    bus.biu_adro = 64'h2000_1000;
    respond(1, 0, 64'hDEAD, 1);
    #1 check("s1_adro_pass", bus.mem_adro, 64'h2000_1000);
    step();
    rsp_idle();
    #1 check("s1_inflight0", inflight, 0);

    // Back-pressure with QDEPTH=2 and no stb_ack
    drive_req(64'hA0, 0, 1, 64'hD0D0);
    #1 check("bp_ack0", bus.mem_adr_ack, 1);
    step();
    drive_req(64'hA1, 0, 0, 64'h0);
    #1 check("bp_ack1", bus.mem_adr_ack, 1);
    step();
    drive_req(64'hA2, 0, 0, 64'h0);
    #1 check("bp_rdy_full", bus.mem_rdy, 0);
    check("bp_ack2_held", bus.mem_adr_ack, 0);
    check("bp_head_adr", bus.biu_adri, 64'hA0);
    check("bp_head_we", bus.biu_we, 1);
    check("bp_head_d", bus.biu_d, 64'hD0D0);
    step();
    #1 check("bp_still_held", bus.mem_adr_ack, 0);
    bus.biu_stb_ack = 1;
    #1 check("bp_full_on_pop", bus.mem_adr_ack, 0);
    step();
    bus.biu_stb_ack = 0;
    #1 check("bp_rdy_after_pop", bus.mem_rdy, 1);
    check("bp_ack2", bus.mem_adr_ack, 1);
    check("bp_head_a1", bus.biu_adri, 64'hA1);
    step();
    bus.mem_req = 0;

    // DEPTH=2 limit
    bus.biu_stb_ack = 1;
    step();
    #1 check("dl_inflight2", inflight, 2);
    check("dl_stb_drop", bus.biu_stb, 0);
    step();
    #1 check("dl_stb_still_low", bus.biu_stb, 0);
    respond(1, 0, 64'h1111, 1);
    step();
    rsp_idle();
    #1 check("dl_third_issues", bus.biu_stb, 1);
    check("dl_third_adr", bus.biu_adri, 64'hA2);
    step();
    bus.biu_stb_ack = 0;
    #1 check("dl_inflight2b", inflight, 2);

    // Clear with 2 in flight, a queued request and a response in the same cycle
    drive_req(64'hA9, 0, 0, 64'h0);
    step();
    bus.mem_req = 0;
    clr = 1;
    respond(1, 0, 64'h2222, 0);
    #1 check("clr_rdy_low", bus.mem_rdy, 0);
    check("clr_no_ack", bus.mem_ack, 0);
    step();
    clr = 0;
    rsp_idle();
    #1 check("clr_fifo_empty", bus.biu_stb, 0);
    check("clr_inflight1", inflight, 1);
    respond(1, 0, 64'h3333, 0);
    #1 check("clr_suppressed", bus.mem_ack, 0);
    step();
    rsp_idle();
    #1 check("clr_inflight0", inflight, 0);
    drive_req(64'hA3, 0, 0, 64'h0);
    step();
    bus.mem_req = 0;
    bus.biu_stb_ack = 1;
    step();
    bus.biu_stb_ack = 0;
    respond(1, 0, 64'h4444, 1);
    step();
    rsp_idle();

    // Lock serialisation
    drive_req(64'hB0, 0, 0, 64'h0);
    step();
    drive_req(64'hB1, 1, 0, 64'h0);
    bus.biu_stb_ack = 1;
    step();
    bus.biu_stb_ack = 0;
    drive_req(64'hB2, 0, 0, 64'h0);
    #1 check("lk_head_locked", bus.biu_lock, 1);
    check("lk_blocked", bus.biu_stb, 0);
    step();
    bus.mem_req = 0;
    #1 check("lk_blocked2", bus.biu_stb, 0);
    respond(1, 0, 64'h5555, 1);
    step();
    rsp_idle();
    #1 check("lk_issue", bus.biu_stb, 1);
    check("lk_issue_adr", bus.biu_adri, 64'hB1);
    bus.biu_stb_ack = 1;
    step();
    #1 check("lk_c_stalls", bus.biu_stb, 0);
    check("lk_c_head", bus.biu_adri, 64'hB2);
    step();
    #1 check("lk_c_stalls2", bus.biu_stb, 0);
    respond(1, 0, 64'h6666, 1);
    step();
    rsp_idle();
    #1 check("lk_c_issue", bus.biu_stb, 1);
    step();
    bus.biu_stb_ack = 0;

    // Error response
    respond(0, 1, 64'h0, 1);
    #1 check("err_no_ack", bus.mem_ack, 0);
    step();
    rsp_idle();
    #1 check("err_inflight0", inflight, 0);

    // Unsolicited response with nothing in flight
    respond(1, 0, 64'h7777, 0);
    #1 check("unsol_no_ack", bus.mem_ack, 0);
    step();
    rsp_idle();
    #1 check("unsol_no_underflow", inflight, 0);

    // Asynchronous reset mid-operation
    drive_req(64'hC0, 0, 0, 64'h0);
    step();
    bus.mem_req = 0;
    bus.biu_stb_ack = 1;
    step();
    bus.biu_stb_ack = 0;
    #1 check("ar_inflight1", inflight, 1);
    #1 rst_n = 0;
    #1 check("ar_inflight0", inflight, 0);
    check("ar_stb", bus.biu_stb, 0);
    check("ar_rdy", bus.mem_rdy, 1);
    step();
    rst_n = 1;
    step();
    respond(1, 0, 64'h8888, 0);
    step();
    rsp_idle();
    #1 check("ar_unsol_dropped", inflight, 0);

    step(); step();
    check("rsp_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_riscv_dext_q.md
# pu_riscv_dext_q

Queued data external access unit between the data-side memory pipeline and the BIU. It buffers up to QDEPTH CPU requests in a FIFO and keeps up to DEPTH transactions outstanding on the BIU. It serialises locked accesses and discards stale responses after a pipeline clear. Responses are in order and pass through combinationally.

## Interface
- XLEN, 64, data/virtual address width
- PLEN, 64, physical address width
- DEPTH, 4, max outstanding BIU transactions (≥1)
- QDEPTH, 2, request FIFO entries (power of 2, ≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clr_i  in  1  flush queue and discard in-flight responses
- mem_req_i  in  1  CPU request valid
- mem_rdy_o  out  1  FIFO can accept (not full, ~clr_i)
- mem_adr_i  in  XLEN  address
- mem_size_i / mem_type_i / mem_prot_i  in  3 each  size, burst type, protection
- mem_lock_i, mem_we_i  in  1 each  locked access, write enable
- mem_d_i  in  XLEN  write data
- mem_adr_ack_o  out  1  request accepted into FIFO
- mem_adr_o  out  PLEN  = biu_adro_i
- mem_q_o  out  XLEN  = biu_q_i
- mem_ack_o, mem_err_o  out  1 each  data ack / error to CPU
- biu_stb_o  out  1  request to BIU
- biu_stb_ack_i  in  1  BIU accepted request
- biu_adri_o  out  PLEN  head address (zero-extended/truncated from XLEN)
- biu_adro_i  in  PLEN  BIU address out
- biu_size_o / biu_type_o / biu_prot_o  out  3 each  head fields
- biu_lock_o, biu_we_o  out  1 each  head fields
- biu_d_o  out  XLEN  head write data
- biu_q_i  in  XLEN  read data
- biu_ack_i, biu_err_i  in  1 each  response ack / error (one per transfer)
- inflight_o  out  $clog2(DEPTH+1)  outstanding count

## Operation
- Accept = mem_req_i & mem_rdy_o. Push all request fields. mem_adr_ack_o = accept. Requests with mem_rdy_o=0 are not captured; the CPU holds them.
- Issue condition: FIFO non-empty & ~clr_i & inflight<DEPTH & ~lock_block. biu_stb_o = issue condition. biu_* fields always reflect the FIFO head.
- lock_block = (head lock & inflight≠0) | locked_pending. locked_pending sets when a locked request is stb-acked and clears on its response. A locked access therefore runs alone on the bus.
- Pop on biu_stb_o & biu_stb_ack_i. biu_stb_ack_i is ignored when biu_stb_o=0.
- inflight update: +1 on issue-ack only, −1 on response (biu_ack_i|biu_err_i) only, unchanged when both occur. Saturation/underflow is never reached under the legal BIU protocol. A response with inflight=0 is dropped and does not decrement.
- clr_i: FIFO emptied next cycle and locked_pending is kept. discard ← inflight − (response this cycle & inflight≠0 ? 1 : 0).
- Without clr_i: a response with discard≠0 decrements discard.
- mem_ack_o = biu_ack_i & discard==0 & inflight≠0 & ~clr_i. mem_err_o uses biu_err_i with the same qualification.
- Write data, address and attributes are held unchanged in FIFO until pop.

## Timing
- Reset values: FIFO empty, inflight=0, discard=0, locked_pending=0.
- Output values in reset: mem_rdy_o=1, biu_stb_o=0, mem_adr_ack_o=0, mem_ack_o=0, mem_err_o=0, inflight_o=0. biu_* fields are don't-care but defined as 0.
- Latency: accept in cycle N → earliest biu_stb_o in N+1. No same-cycle bypass.
- Response → mem_ack_o/mem_err_o in the same cycle (combinational).
- Full FIFO: mem_rdy_o=0 even if a pop occurs that cycle. Push into a popping full FIFO is not allowed.
- Pointers wrap modulo QDEPTH. full/empty are derived from the count register.
- Reset mid-operation clears everything immediately (async). BIU responses after reset are dropped as unsolicited.
- clr_i with accept attempt: no accept, because mem_rdy_o is low.

## Test plan
- Single read: mem_req_i at cycle 0, adr 0x1000 → biu_stb_o at cycle 1, adr 0x1000. stb_ack → inflight_o=1. biu_ack_i with q=0xDEAD → mem_ack_o=1, mem_q_o=0xDEAD, inflight_o=0.
- Back-pressure: QDEPTH=2, BIU never acks stb, push 3 requests → first 2 get mem_adr_ack_o. mem_rdy_o=0 from the cycle after the second push. Third held until the first pop.
- DEPTH limit: DEPTH=2, 3 requests stb-acked immediately, no responses → biu_stb_o drops with inflight_o=2. One biu_ack_i → third issues the next cycle.
- Clear with 2 in flight, response in same cycle as clr_i → no mem_ack_o, discard=1. Next response is suppressed. Third response after a new request → mem_ack_o=1.
- Lock: request A (unlocked) in flight, head B locked → biu_stb_o=0 until A's ack. B issues, request C stalls until B's ack.
- Error: biu_err_i on an outstanding read → mem_err_o=1, mem_ack_o=0, inflight decrements.
